// File: rtl/tmr_pkg.sv
// Shared types and the bitwise majority vote used by every TMR read point.
package tmr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    FIX  = 2'd2
  } scrub_state_e;

  // Widest entry the vote helper supports; callers cast down to their width.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] maj3(input logic [MAX_W-1:0] a,
                                            input logic [MAX_W-1:0] b,
                                            input logic [MAX_W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tmr_reg_scrubber_if.sv
// Write, read, fault-injection and scrub-status bundle of the TMR register bank.
interface tmr_reg_scrubber_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_valid;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_req;
  logic [AW-1:0]    rd_addr;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_err;
  logic             inj_en;
  logic [1:0]       inj_copy;
  logic [AW-1:0]    inj_addr;
  logic [WIDTH-1:0] inj_mask;
  logic             err_pulse;
  logic [CNT_W-1:0] err_cnt;
  logic             scrub_busy;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_req, rd_addr,
           inj_en, inj_copy, inj_addr, inj_mask,
    input  wr_ready, rd_valid, rd_data, rd_err, err_pulse, err_cnt, scrub_busy
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_req, rd_addr,
           inj_en, inj_copy, inj_addr, inj_mask,
    output wr_ready, rd_valid, rd_data, rd_err, err_pulse, err_cnt, scrub_busy
  );
endinterface

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 vote over one entry plus a flag when any copy disagrees with it.
module tmr_vote
  import tmr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] voted,
  output logic             mismatch
);

  assign voted    = WIDTH'(maj3(MAX_W'(a), MAX_W'(b), MAX_W'(c)));
  assign mismatch = (a != voted) || (b != voted) || (c != voted);

endmodule

// File: rtl/tmr_reg_scrubber.sv
// Triple-redundant register bank with voted read-back and a background scrubber
// that rewrites any entry whose three copies disagree.
//
// state | meaning
// IDLE  | gap timer counting down to the next scrub step
// READ  | vote entry scrub_ptr, decide repair or advance
// FIX   | write voted value to all copies of scrub_ptr, count the repair
module tmr_reg_scrubber
  import tmr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RSTVAL    = {WIDTH{1'b0}},
  parameter int               SCRUB_GAP = 16,
  parameter int               CNT_W     = 8
) (
  input logic               clk,
  input logic               rst,
  tmr_reg_scrubber_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int GAP_W = $clog2(SCRUB_GAP + 2);

  logic [WIDTH-1:0] mem [3][DEPTH];
  scrub_state_e     state;
  logic [GAP_W-1:0] gap_cnt;
  logic [AW-1:0]    scrub_ptr;
  logic [AW-1:0]    ptr_next;
  logic [WIDTH-1:0] fix_data;
  logic [WIDTH-1:0] rd_vote, sc_vote;
  logic             rd_mis, sc_mis;
  logic             wr_fire, stale;
  logic             wr_ready_q, scrub_busy_q, err_pulse_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic             rd_valid_q, rd_err_q;
  logic [WIDTH-1:0] rd_data_q;

  tmr_vote #(.WIDTH(WIDTH)) u_rd_vote (
    .a(mem[0][bus.rd_addr]), .b(mem[1][bus.rd_addr]), .c(mem[2][bus.rd_addr]),
    .voted(rd_vote), .mismatch(rd_mis)
  );

  tmr_vote #(.WIDTH(WIDTH)) u_sc_vote (
    .a(mem[0][scrub_ptr]), .b(mem[1][scrub_ptr]), .c(mem[2][scrub_ptr]),
    .voted(sc_vote), .mismatch(sc_mis)
  );

  assign wr_fire  = bus.wr_valid && wr_ready_q;
  // A write landing on the entry under vote makes that vote obsolete.
  assign stale    = wr_fire && (bus.wr_addr == scrub_ptr);
  assign ptr_next = (scrub_ptr == AW'(DEPTH - 1)) ? '0 : scrub_ptr + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 3; c++)
        for (int e = 0; e < DEPTH; e++)
          mem[c][e] <= RSTVAL;
    end else begin
      for (int c = 0; c < 3; c++)
        for (int e = 0; e < DEPTH; e++)
          if (state == FIX && scrub_ptr == AW'(e))
            mem[c][e] <= fix_data;
          else if (wr_fire && bus.wr_addr == AW'(e))
            mem[c][e] <= bus.wr_data;
          else if (bus.inj_en && bus.inj_copy == 2'(c) && bus.inj_addr == AW'(e))
            mem[c][e] <= mem[c][e] ^ bus.inj_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      gap_cnt      <= GAP_W'(SCRUB_GAP);
      scrub_ptr    <= '0;
      fix_data     <= '0;
      wr_ready_q   <= 1'b1;
      scrub_busy_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      case (state)
        IDLE: begin
          if (gap_cnt <= GAP_W'(1)) begin
            state        <= READ;
            scrub_busy_q <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        READ: begin
          if (sc_mis && !stale) begin
            state      <= FIX;
            fix_data   <= sc_vote;
            wr_ready_q <= 1'b0;
          end else begin
            scrub_ptr    <= ptr_next;
            gap_cnt      <= GAP_W'(SCRUB_GAP);
            state        <= (SCRUB_GAP == 0) ? READ : IDLE;
            scrub_busy_q <= (SCRUB_GAP == 0);
          end
        end
        FIX: begin
          err_pulse_q  <= 1'b1;
          if (err_cnt_q != {CNT_W{1'b1}})
            err_cnt_q <= err_cnt_q + 1'b1;
          scrub_ptr    <= ptr_next;
          gap_cnt      <= GAP_W'(SCRUB_GAP);
          wr_ready_q   <= 1'b1;
          state        <= (SCRUB_GAP == 0) ? READ : IDLE;
          scrub_busy_q <= (SCRUB_GAP == 0);
        end
        default: begin
          state        <= IDLE;
          scrub_busy_q <= 1'b0;
          wr_ready_q   <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_req;
      if (bus.rd_req) begin
        rd_data_q <= rd_vote;
        rd_err_q  <= rd_mis;
      end
    end
  end

  assign bus.wr_ready   = wr_ready_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_err     = rd_err_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.scrub_busy = scrub_busy_q;

endmodule
